// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: opcodes, writeback/pcselect codes and the execute control word layout for the LC3 decode stage
package lc3_decode_pkg;
    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_LD  = 4'b0010,
        OP_ST  = 4'b0011,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_LDI = 4'b1010,
        OP_STI = 4'b1011,
        OP_JMP = 4'b1100,
        OP_LEA = 4'b1110
    } opcode_t;

    localparam logic [1:0] W_ALU = 2'd0;
    localparam logic [1:0] W_MEM = 2'd1;
    localparam logic [1:0] W_PC  = 2'd2;

    localparam logic [1:0] PCS1_OFF9 = 2'd1;
    localparam logic [1:0] PCS1_OFF6 = 2'd2;
    localparam logic [1:0] PCS1_ZERO = 2'd3;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;
endpackage

// File: rtl/lc3_decode_ctrl.sv
// lc3_decode_ctrl: combinational opcode -> {E_Control, W_Control, Mem_Control} lookup
//   opcode   in  4  instruction bits [15:12]
//   imm_sel  in  1  instruction bit 5 (1 = imm5 operand for ADD/AND)
//   e_ctrl   out 6  execute control word
//   w_ctrl   out 2  writeback source select
//   m_ctrl   out 1  indirect memory access (LDI/STI)
module lc3_decode_ctrl
    import lc3_decode_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       imm_sel,
    output e_ctrl_t    e_ctrl,
    output logic [1:0] w_ctrl,
    output logic       m_ctrl
);
    always_comb begin
        e_ctrl = '0;
        case (opcode)
            OP_ADD: e_ctrl.op2select = ~imm_sel;
            OP_AND: begin
                e_ctrl.alu_control = 2'd1;
                e_ctrl.op2select   = ~imm_sel;
            end
            OP_NOT: begin
                e_ctrl.alu_control = 2'd2;
                e_ctrl.op2select   = 1'b1;
            end
            OP_BR, OP_LD, OP_LDI, OP_ST, OP_STI, OP_LEA: begin
                e_ctrl.pcselect1 = PCS1_OFF9;
                e_ctrl.pcselect2 = 1'b1;
            end
            OP_LDR, OP_STR: e_ctrl.pcselect1 = PCS1_OFF6;
            OP_JMP:         e_ctrl.pcselect1 = PCS1_ZERO;
            default:        e_ctrl = '0;
        endcase
    end

    assign w_ctrl = (opcode == OP_LD || opcode == OP_LDR || opcode == OP_LDI) ? W_MEM :
                    (opcode == OP_LEA) ? W_PC : W_ALU;
    assign m_ctrl = (opcode == OP_LDI || opcode == OP_STI);
endmodule

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: LC3 decode pipeline register; captures instruction, next-PC and decoded controls
//   clock, reset   clock and async active-high reset
//   enable_decode  capture enable (low = hold)
//   dout, npc_in   instruction word and its PC+1
//   IR, npc_out    registered instruction and next-PC
//   E_Control, W_Control, Mem_Control  registered control words decoded from dout
module lc3_decode_stage
    import lc3_decode_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] IR_RST = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_Control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control
);
    e_ctrl_t    e_next;
    logic [1:0] w_next;
    logic       m_next;

    // Controls come from the incoming word so they line up with IR in the same cycle.
    lc3_decode_ctrl u_ctrl (
        .opcode  (dout[15:12]),
        .imm_sel (dout[5]),
        .e_ctrl  (e_next),
        .w_ctrl  (w_next),
        .m_ctrl  (m_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR          <= IR_RST;
            npc_out     <= '0;
            E_Control   <= '0;
            W_Control   <= W_ALU;
            Mem_Control <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_Control   <= e_next;
            W_Control   <= w_next;
            Mem_Control <= m_next;
        end
    end
endmodule
